// File: rtl/div_issue_ctrl_pkg.sv
// Shared types for the EX-stage divider issue controller: ALU op encoding and controller states.
package div_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl,
    AluSra,
    AluSlt,
    AluSltu,
    AluMul,
    AluDiv,
    AluDivu,
    AluRem,
    AluRemu
  } alu_t;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone,
    StResp
  } div_ctrl_state_t;

  function automatic logic alu_is_signed_div(input alu_t op);
    return (op == AluDiv) || (op == AluRem);
  endfunction

  function automatic logic alu_is_rem(input alu_t op);
    return (op == AluRem) || (op == AluRemu);
  endfunction

endpackage

// File: rtl/div_issue_ctrl_special.sv
// Detects divide-by-zero and signed overflow and produces the RISC-V defined result directly.
module div_special_case
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  alu_t             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             is_special_o,
  output logic [WIDTH-1:0] fix_data_o
);

  logic [WIDTH-1:0] int_min;
  logic             is_rem;

  assign int_min = {1'b1, {(WIDTH - 1){1'b0}}};
  assign is_rem  = alu_is_rem(op_i);

  always_comb begin
    is_special_o = 1'b0;
    fix_data_o   = '0;
    if (b_i == '0) begin
      is_special_o = 1'b1;
      fix_data_o   = is_rem ? a_i : '1;
    end else if (alu_is_signed_div(op_i) && (a_i == int_min) && (b_i == '1)) begin
      // INT_MIN / -1 overflows: quotient wraps to INT_MIN, remainder is zero
      is_special_o = 1'b1;
      fix_data_o   = is_rem ? '0 : a_i;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/sequencing controller wrapping the iterative divider: accept, launch, wait, respond.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  alu_t             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [4:0]       req_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [4:0]       rsp_rd,
  output logic             busy,
  output logic [4:0]       busy_rd,
  output logic             timeout_err,
  output logic             div_start,
  output alu_t             div_alu_ctrl,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_en,
  output logic             div_clear,
  input  logic             div_stall,
  input  logic [WIDTH-1:0] div_result
);

  localparam int unsigned     CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  div_ctrl_state_t  state_q;
  logic [CntW-1:0]  wd_cnt_q;
  logic [4:0]       rd_q;
  logic             is_special;
  logic [WIDTH-1:0] fix_data;
  logic             div_active;

  div_special_case #(
    .WIDTH(WIDTH)
  ) u_special (
    .op_i        (req_op),
    .a_i         (req_a),
    .b_i         (req_b),
    .is_special_o(is_special),
    .fix_data_o  (fix_data)
  );

  assign req_ready  = (state_q == StIdle) && !flush;
  assign busy       = (state_q != StIdle);
  assign busy_rd    = busy ? rd_q : 5'd0;
  assign rsp_rd     = rd_q;
  assign div_en     = 1'b1;
  assign div_active = (state_q == StLaunch) || (state_q == StWaitBusy) ||
                      (state_q == StWaitDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wd_cnt_q     <= '0;
      rd_q         <= 5'd0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      timeout_err  <= 1'b0;
      div_start    <= 1'b0;
      div_clear    <= 1'b0;
      div_alu_ctrl <= AluDiv;
      div_a        <= '0;
      div_b        <= '0;
    end else begin
      div_start <= 1'b0;
      div_clear <= 1'b0;
      if (flush) begin
        // Only a divider that may be iterating needs to be cleared
        div_clear <= div_active;
        rsp_valid <= 1'b0;
        state_q   <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (req_valid) begin
              div_alu_ctrl <= req_op;
              div_a        <= req_a;
              div_b        <= req_b;
              rd_q         <= req_rd;
              if (is_special) begin
                rsp_data  <= fix_data;
                rsp_valid <= 1'b1;
                state_q   <= StResp;
              end else begin
                div_start <= 1'b1;
                state_q   <= StLaunch;
              end
            end
          end
          StLaunch: begin
            wd_cnt_q <= '0;
            state_q  <= StWaitBusy;
          end
          StWaitBusy: begin
            if (wd_cnt_q == CntMax) begin
              div_clear   <= 1'b1;
              timeout_err <= 1'b1;
              state_q     <= StIdle;
            end else begin
              wd_cnt_q <= wd_cnt_q + 1'b1;
              if (div_stall) state_q <= StWaitDone;
            end
          end
          StWaitDone: begin
            if (wd_cnt_q == CntMax) begin
              div_clear   <= 1'b1;
              timeout_err <= 1'b1;
              state_q     <= StIdle;
            end else begin
              wd_cnt_q <= wd_cnt_q + 1'b1;
              if (!div_stall) begin
                rsp_data  <= div_result;
                rsp_valid <= 1'b1;
                state_q   <= StResp;
              end
            end
          end
          StResp: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              state_q   <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural iterative-divider stand-in.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  alu_t             req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [4:0]       req_rd;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [4:0]       rsp_rd;
  logic             busy;
  logic [4:0]       busy_rd;
  logic             timeout_err;
  logic             div_start;
  alu_t             div_alu_ctrl;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_en;
  logic             div_clear;
  logic             div_stall;
  logic [WIDTH-1:0] div_result;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int lat;
  logic stuck = 1'b0;
  logic [WIDTH-1:0] pend;
  int unsigned dcnt;

  always #5 clk = ~clk;

  div_issue_ctrl #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rd      (req_rd),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_rd      (rsp_rd),
    .busy        (busy),
    .busy_rd     (busy_rd),
    .timeout_err (timeout_err),
    .div_start   (div_start),
    .div_alu_ctrl(div_alu_ctrl),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_en      (div_en),
    .div_clear   (div_clear),
    .div_stall   (div_stall),
    .div_result  (div_result)
  );

  function automatic logic [WIDTH-1:0] div_model(input alu_t op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      AluDiv:  return WIDTH'($signed(a) / $signed(b));
      AluRem:  return WIDTH'($signed(a) % $signed(b));
      AluDivu: return a / b;
      AluRemu: return a % b;
      default: return '0;
    endcase
  endfunction

  // Divider stand-in: stall rises the cycle after start and drops WIDTH+1 cycles later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_stall  <= 1'b0;
      div_result <= '0;
      dcnt       <= 0;
      pend       <= '0;
    end else if (div_clear) begin
      div_stall <= 1'b0;
    end else if (div_start) begin
      div_stall <= 1'b1;
      dcnt      <= WIDTH;
      pend      <= div_model(div_alu_ctrl, div_a, div_b);
    end else if (div_stall && !stuck) begin
      if (dcnt == 0) begin
        div_stall  <= 1'b0;
        div_result <= pend;
      end else begin
        dcnt <= dcnt - 1;
      end
    end
  end

  always @(posedge clk) if (div_start) start_cnt <= start_cnt + 1;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request; returns 1 ns after the accepting edge
  task automatic issue(input alu_t op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [4:0] rd);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      step(1);
      w++;
    end
    check("req_ready_before_issue", WIDTH'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
    step(1);
    req_valid = 1'b0;
  endtask

  // lat = number of cycles from the accept cycle to the first cycle with rsp_valid
  task automatic wait_rsp(output int l);
    l = 1;
    while (!rsp_valid && l < 200) begin
      step(1);
      l++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int s0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = AluAdd;
    req_a     = '0;
    req_b     = '0;
    req_rd    = 5'd0;
    rsp_ready = 1'b0;
    #12;
    check("rst_rsp_valid", WIDTH'(rsp_valid), 0);
    check("rst_busy", WIDTH'(busy), 0);
    check("rst_div_en", WIDTH'(div_en), 1);
    check("rst_alu_ctrl", WIDTH'(div_alu_ctrl), WIDTH'(AluDiv));
    check("rst_div_start", WIDTH'(div_start), 0);
    check("rst_timeout_err", WIDTH'(timeout_err), 0);
    rst_n = 1'b1;
    step(2);

    // Normal DIV through the divider
    issue(AluDiv, 32'd100, 32'd7, 5'd5);
    check("div_start_pulse", WIDTH'(div_start), 1);
    check("busy_rd_held", WIDTH'(busy_rd), 5);
    step(1);
    check("div_start_one_cycle", WIDTH'(div_start), 0);
    wait_rsp(lat);
    lat = lat + 1;
    check("div_latency", lat, 36);
    check("div_100_7", rsp_data, 32'd14);
    check("div_rd", WIDTH'(rsp_rd), 5);
    handshake();
    check("busy_after_hs", WIDTH'(busy), 0);

    issue(AluRem, 32'd100, 32'd7, 5'd6);
    wait_rsp(lat);
    check("rem_100_7", rsp_data, 32'd2);
    handshake();

    issue(AluDiv, 32'hFFFF_FFF9, 32'd2, 5'd7);
    wait_rsp(lat);
    check("div_m7_2", rsp_data, 32'hFFFF_FFFD);
    handshake();

    // Special cases resolve in one cycle without the divider
    s0 = start_cnt;
    issue(AluRemu, 32'd7, 32'd0, 5'd8);
    wait_rsp(lat);
    check("remu_div0_lat", lat, 1);
    check("remu_div0", rsp_data, 32'd7);
    check("remu_rd", WIDTH'(rsp_rd), 8);
    handshake();
    issue(AluDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    wait_rsp(lat);
    check("div_ovf_lat", lat, 1);
    check("div_ovf", rsp_data, 32'h8000_0000);
    handshake();
    issue(AluRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    wait_rsp(lat);
    check("rem_ovf", rsp_data, 32'd0);
    handshake();
    issue(AluDivu, 32'd5, 32'd0, 5'd11);
    wait_rsp(lat);
    check("divu_div0", rsp_data, 32'hFFFF_FFFF);
    handshake();
    check("special_no_start", start_cnt - s0, 0);

    // Response held under back-pressure, rd=0 returned as-is
    issue(AluDivu, 32'd50, 32'd6, 5'd0);
    wait_rsp(lat);
    step(10);
    check("bp_valid", WIDTH'(rsp_valid), 1);
    check("bp_data", rsp_data, 32'd8);
    check("bp_rd", WIDTH'(rsp_rd), 0);
    check("bp_req_ready", WIDTH'(req_ready), 0);
    check("bp_busy", WIDTH'(busy), 1);
    handshake();
    check("bp_after_valid", WIDTH'(rsp_valid), 0);
    check("bp_after_ready", WIDTH'(req_ready), 1);

    // Flush mid-divide
    issue(AluDiv, 32'd100, 32'd7, 5'd3);
    step(9);
    flush = 1'b1;
    check("flush_req_ready", WIDTH'(req_ready), 0);
    step(1);
    flush = 1'b0;
    check("flush_clear", WIDTH'(div_clear), 1);
    check("flush_busy", WIDTH'(busy), 0);
    check("flush_busy_rd", WIDTH'(busy_rd), 0);
    step(1);
    check("flush_clear_one", WIDTH'(div_clear), 0);
    step(40);
    check("flush_no_rsp", WIDTH'(rsp_valid), 0);
    issue(AluDiv, 32'd9, 32'd3, 5'd4);
    wait_rsp(lat);
    check("div_9_3", rsp_data, 32'd3);
    handshake();

    // Watchdog on a divider that never finishes
    stuck = 1'b1;
    issue(AluDiv, 32'd9, 32'd3, 5'd12);
    lat = 1;
    while (!timeout_err && lat < 200) begin
      step(1);
      lat++;
    end
    check("wd_latency", lat, 67);
    check("wd_err", WIDTH'(timeout_err), 1);
    check("wd_clear", WIDTH'(div_clear), 1);
    check("wd_no_rsp", WIDTH'(rsp_valid), 0);
    check("wd_busy", WIDTH'(busy), 0);
    stuck = 1'b0;
    step(2);

    // Flush in RESP beats rsp_ready and leaves timeout_err set
    issue(AluDivu, 32'd5, 32'd0, 5'd13);
    flush     = 1'b1;
    rsp_ready = 1'b1;
    step(1);
    flush     = 1'b0;
    rsp_ready = 1'b0;
    check("resp_flush_valid", WIDTH'(rsp_valid), 0);
    check("resp_flush_noclear", WIDTH'(div_clear), 0);
    check("flush_keeps_err", WIDTH'(timeout_err), 1);

    // Async reset mid-op
    issue(AluDivu, 32'd77, 32'd5, 5'd14);
    step(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", WIDTH'(busy), 0);
    check("arst_err", WIDTH'(timeout_err), 0);
    check("arst_alu", WIDTH'(div_alu_ctrl), WIDTH'(AluDiv));
    check("arst_div_a", div_a, 0);
    check("arst_rd", WIDTH'(rsp_rd), 0);
    check("arst_div_en", WIDTH'(div_en), 1);
    #10;
    rst_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
